// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the unified instruction/data memory initiator.
// Holds the FSM state and port-select enums plus byte-to-word address helpers.
package mem_port_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFS_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } port_sel_t;

    function automatic logic [WORD_W-BYTE_OFS_W-1:0] word_index(input logic [WORD_W-1:0] addr);
        return addr[WORD_W-1:BYTE_OFS_W];
    endfunction

endpackage

// File: rtl/mem_port_initiator_if.sv
// CPU fetch/data request ports and memory bus of the initiator, in one bundle.
// The master modport is the initiator; slave is the CPU/memory side.
interface mem_port_initiator_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_we, mem_wd
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_we, mem_wd
    );

endinterface

// File: rtl/mem_addr_xlate.sv
// Combinational byte-address to memory word-index translation with range check.
// Zero latency; no handshake.
module mem_addr_xlate
    import mem_port_pkg::*;
(
    input  logic [WORD_W-1:0] base,
    input  logic [WORD_W-1:0] size,
    input  logic [WORD_W-1:0] byte_addr,
    output logic [WORD_W-1:0] idx,
    output logic              misaligned,
    output logic              out_of_range
);

    logic [WORD_W-1:0] ofs;

    // Full-width offset so large addresses never alias back into the region.
    assign ofs          = {{BYTE_OFS_W{1'b0}}, word_index(byte_addr)};
    assign idx          = base + ofs;
    assign misaligned   = |byte_addr[BYTE_OFS_W-1:0];
    assign out_of_range = (ofs >= size);

endmodule

// File: rtl/mem_port_initiator.sv
// Arbitrates fetch/data requests (data wins) onto one word memory; grant N, access N+1,
// rvalid N+2. Grants only in IDLE/RESP, so a held request waits; one access per 2 cycles.
module mem_port_initiator
    import mem_port_pkg::*;
#(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int DATA_MEM_SIZE  = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    mem_port_initiator_if.master bus
);

    state_t           state;
    port_sel_t        sel;
    logic             l_we;
    logic [WORD_W-1:0] l_addr;
    logic [WORD_W-1:0] l_wdata;

    logic              grant_ok;
    logic              in_access;
    logic              is_store;
    logic              acc_err;
    logic [WORD_W-1:0] base;
    logic [WORD_W-1:0] size;
    logic [WORD_W-1:0] idx;
    logic              misaligned;
    logic              out_of_range;
    logic [WORD_W-1:0] resp_data;

    assign grant_ok   = rstn && (state == IDLE || state == RESP);
    assign bus.d_gnt  = grant_ok && bus.d_req;
    assign bus.if_gnt = grant_ok && bus.if_req && !bus.d_req;

    assign base = (sel == PORT_D) ? WORD_W'(INSTR_MEM_SIZE) : '0;
    assign size = (sel == PORT_D) ? WORD_W'(DATA_MEM_SIZE) : WORD_W'(INSTR_MEM_SIZE);

    mem_addr_xlate u_xlate (
        .base         (base),
        .size         (size),
        .byte_addr    (l_addr),
        .idx          (idx),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    assign in_access = (state == ACCESS);
    assign is_store  = (sel == PORT_D) && l_we;
    assign acc_err   = misaligned || out_of_range;

    // Erroneous accesses never reach the memory; rstn gating blocks writes in a reset cycle.
    assign bus.mem_addr = (in_access && !acc_err) ? idx : '0;
    assign bus.mem_we   = rstn && in_access && is_store && !acc_err;
    assign bus.mem_wd   = (in_access && is_store && !acc_err) ? l_wdata : '0;

    assign resp_data = (acc_err || is_store) ? '0 : bus.mem_rd;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            sel           <= PORT_IF;
            l_we          <= 1'b0;
            l_addr        <= '0;
            l_wdata       <= '0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_err    <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_err     <= 1'b0;
        end else begin
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (bus.d_gnt) begin
                        sel     <= PORT_D;
                        l_we    <= bus.d_we;
                        l_addr  <= bus.d_addr;
                        l_wdata <= bus.d_wdata;
                        state   <= ACCESS;
                    end else if (bus.if_gnt) begin
                        sel     <= PORT_IF;
                        l_we    <= 1'b0;
                        l_addr  <= bus.if_addr;
                        l_wdata <= '0;
                        state   <= ACCESS;
                    end else begin
                        state   <= IDLE;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (sel == PORT_D) begin
                        bus.d_rvalid <= 1'b1;
                        bus.d_rdata  <= resp_data;
                        bus.d_err    <= acc_err;
                    end else begin
                        bus.if_rvalid <= 1'b1;
                        bus.if_rdata  <= resp_data;
                        bus.if_err    <= acc_err;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed bench: vector table of single accesses plus arbitration and reset sequences.
module tb_mem_port_initiator;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    mem_port_initiator_if bus ();

    mem_port_initiator #(
        .INSTR_MEM_SIZE (32),
        .DATA_MEM_SIZE  (32)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] mem [0:63];

    assign bus.mem_rd = (bus.mem_addr < 32'd64) ? mem[bus.mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_addr < 32'd64) mem[bus.mem_addr[5:0]] <= bus.mem_wd;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_addr;
        logic [31:0] exp_mem_addr;
        logic        exp_we;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [31:0] got;
        v = vecs[i];
        @(posedge clk); #1;
        if (v.is_d) begin
            bus.d_req   = 1'b1;
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = v.addr;
        end
        @(negedge clk);
        check($sformatf("v%0d_gnt", i), v.is_d ? bus.d_gnt : bus.if_gnt, 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check($sformatf("v%0d_mem_we", i), bus.mem_we, v.exp_we);
        if (v.chk_addr) check($sformatf("v%0d_mem_addr", i), bus.mem_addr, v.exp_mem_addr);
        if (v.exp_we) check($sformatf("v%0d_mem_wd", i), bus.mem_wd, v.wdata);
        check($sformatf("v%0d_early_rvalid", i), v.is_d ? bus.d_rvalid : bus.if_rvalid, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_rvalid", i), v.is_d ? bus.d_rvalid : bus.if_rvalid, 32'd1);
        check($sformatf("v%0d_other_rvalid", i), v.is_d ? bus.if_rvalid : bus.d_rvalid, 32'd0);
        got = v.is_d ? bus.d_rdata : bus.if_rdata;
        check($sformatf("v%0d_rdata", i), got, v.exp_rdata);
        check($sformatf("v%0d_err", i), v.is_d ? bus.d_err : bus.if_err, v.exp_err);
        check($sformatf("v%0d_resp_mem_we", i), bus.mem_we, 32'd0);
        check($sformatf("v%0d_resp_mem_addr", i), bus.mem_addr, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_pulse_end", i), v.is_d ? bus.d_rvalid : bus.if_rvalid, 32'd0);
        check($sformatf("v%0d_rdata_hold", i), v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
        check($sformatf("v%0d_err_hold", i), v.is_d ? bus.d_err : bus.if_err, v.exp_err);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        mem[2] = 32'h0000_1234;

        //            is_d  we    addr          wdata         chk   maddr   we    err   rdata
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,        1'b1, 32'd2,  1'b0, 1'b0, 32'h0000_1234};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0004, 32'hDEADBEEF, 1'b1, 32'd33, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b1, 32'd33, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0006, 32'hCAFEF00D, 1'b0, 32'd0,  1'b0, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,        1'b0, 32'd0,  1'b0, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h0,        1'b1, 32'd63, 1'b0, 1'b0, 32'hA000_003F};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_007C, 32'h0,        1'b1, 32'd31, 1'b0, 1'b0, 32'hA000_001F};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        1'b0, 32'd0,  1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h4000_0008, 32'h0,        1'b0, 32'd0,  1'b0, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,        1'b0, 32'd0,  1'b0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_007C, 32'h0000_55AA, 1'b1, 32'd63, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_007C, 32'h0,        1'b1, 32'd63, 1'b0, 1'b0, 32'h0000_55AA};

        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_gnt", bus.if_gnt, 32'd0);
        check("rst_d_gnt", bus.d_gnt, 32'd0);
        check("rst_if_rvalid", bus.if_rvalid, 32'd0);
        check("rst_d_rvalid", bus.d_rvalid, 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_errs", {30'd0, bus.if_err, bus.d_err}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_we", bus.mem_we, 32'd0);
        check("rst_mem_wd", bus.mem_wd, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i);
        check("err_store_no_write", mem[32 + 1], 32'hDEADBEEF);

        // Simultaneous requests: data first, fetch granted in the data response cycle.
        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0008;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0004;
        @(negedge clk);
        check("arb_c0_d_gnt", bus.d_gnt, 32'd1);
        check("arb_c0_if_gnt", bus.if_gnt, 32'd0);
        @(posedge clk); #1;
        bus.d_req  = 1'b0;
        bus.d_addr = 32'h0;
        @(negedge clk);
        check("arb_c1_if_gnt", bus.if_gnt, 32'd0);
        check("arb_c1_mem_addr", bus.mem_addr, 32'd33);
        @(negedge clk);
        check("arb_c2_d_rvalid", bus.d_rvalid, 32'd1);
        check("arb_c2_d_rdata", bus.d_rdata, 32'hDEADBEEF);
        check("arb_c2_if_gnt", bus.if_gnt, 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("arb_c3_mem_addr", bus.mem_addr, 32'd2);
        check("arb_c3_if_rvalid", bus.if_rvalid, 32'd0);
        @(negedge clk);
        check("arb_c4_if_rvalid", bus.if_rvalid, 32'd1);
        check("arb_c4_if_rdata", bus.if_rdata, 32'h0000_1234);
        check("arb_c4_d_rvalid", bus.d_rvalid, 32'd0);

        // Reset asserted during the ACCESS cycle of a store.
        @(posedge clk); #1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0010;
        bus.d_wdata = 32'h1234_5678;
        @(negedge clk);
        check("rmid_gnt", bus.d_gnt, 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        check("rmid_mem_we", bus.mem_we, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rmid_no_rvalid%0d", c), {30'd0, bus.d_rvalid, bus.if_rvalid}, 32'd0);
        end
        check("rmid_d_rdata", bus.d_rdata, 32'd0);
        check("rmid_if_rdata", bus.if_rdata, 32'd0);
        check("rmid_mem_addr", bus.mem_addr, 32'd0);
        check("rmid_mem_kept", mem[36], 32'hA000_0024);
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'd36, 1'b0, 1'b0, 32'hA000_0024};
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
